// File: rtl/riscv_ex_issue_if.sv
// ============================================================================
// Module      : riscv_ex_issue_if
// Description : Decode-to-issue bundle input and ALU operand/control output
//               bundle of the execute-stage issue register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_ex_issue_if #(
    parameter int WIDTH = 64
);
    // Upstream decode bundle
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             flush;

    // Downstream ALU bundle
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [4:0]       rd;
    logic             rd_wen;
    logic             illegal;

    // Environment side: drives the decode bundle, consumes the ALU bundle
    modport master (
        output in_valid, inst, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd, rd_wen, illegal
    );

    // Issue register side
    modport slave (
        input  in_valid, inst, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd, rd_wen, illegal
    );
endinterface

`default_nettype wire

// File: rtl/riscv_ex_issue.sv
// ============================================================================
// Module      : riscv_ex_issue
// Description : RV64I execute-stage issue register. Decodes an instruction
//               into ALU control/operands and holds them in a one-entry
//               valid/ready pipeline register with stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_ex_issue #(
    parameter int WIDTH = 64
) (
    input  wire logic           clk,
    input  wire logic           rst,
    riscv_ex_issue_if.slave     bus
);

    // Opcodes
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] c_OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    // ALU operation codes
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SLL  = 4'b0001;
    localparam logic [3:0] c_ALU_SRL  = 4'b0101;
    localparam logic [3:0] c_ALU_SUB  = 4'b1000;
    localparam logic [3:0] c_ALU_ADDW = 4'b1001;
    localparam logic [3:0] c_ALU_SUBW = 4'b1010;
    localparam logic [3:0] c_ALU_SLLW = 4'b1011;
    localparam logic [3:0] c_ALU_SRLW = 4'b1100;
    localparam logic [3:0] c_ALU_SRA  = 4'b1101;
    localparam logic [3:0] c_ALU_SRAW = 4'b1110;

    // Instruction fields and immediates
    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic [WIDTH-1:0] w_imm_i;
    logic [WIDTH-1:0] w_imm_u;
    logic [WIDTH-1:0] w_shamt6;
    logic [WIDTH-1:0] w_shamt5;
    logic             w_unused_rs_fields;

    assign w_opcode  = bus.inst[6:0];
    assign w_funct3  = bus.inst[14:12];
    assign w_funct7  = bus.inst[31:25];
    assign w_imm_i   = {{(WIDTH-12){bus.inst[31]}}, bus.inst[31:20]};
    assign w_imm_u   = {{(WIDTH-32){bus.inst[31]}}, bus.inst[31:12], 12'b0};
    assign w_shamt6  = {{(WIDTH-6){1'b0}}, bus.inst[25:20]};
    assign w_shamt5  = {{(WIDTH-5){1'b0}}, bus.inst[24:20]};
    // Register-index fields are consumed by the register file, not here
    assign w_unused_rs_fields = ^bus.inst[19:15];

    // Decoded bundle
    logic [3:0]       w_ctrl;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_ill;
    logic             w_known;
    logic [4:0]       w_rd;
    logic             w_wen;

    // Decode instruction into ALU control, operands and legality
    always_comb begin
        w_ctrl  = c_ALU_ADD;
        w_a     = '0;
        w_b     = '0;
        w_ill   = 1'b0;
        w_known = 1'b1;
        case (w_opcode)
            c_OPC_OP: begin
                w_a = bus.rs1_data;
                w_b = bus.rs2_data;
                if (w_funct7 == c_F7_BASE) begin
                    // Base R-type codes coincide with {0, funct3}
                    w_ctrl = {1'b0, w_funct3};
                end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b000) begin
                    w_ctrl = c_ALU_SUB;
                end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b101) begin
                    w_ctrl = c_ALU_SRA;
                end else begin
                    w_ill = 1'b1;
                end
            end
            c_OPC_OP_IMM: begin
                w_a = bus.rs1_data;
                w_b = w_imm_i;
                case (w_funct3)
                    3'b001: begin
                        w_b = w_shamt6;
                        if (bus.inst[31:26] == 6'b000000) w_ctrl = c_ALU_SLL;
                        else                              w_ill  = 1'b1;
                    end
                    3'b101: begin
                        w_b = w_shamt6;
                        if (bus.inst[31:26] == 6'b000000)      w_ctrl = c_ALU_SRL;
                        else if (bus.inst[31:26] == 6'b010000) w_ctrl = c_ALU_SRA;
                        else                                   w_ill  = 1'b1;
                    end
                    default: w_ctrl = {1'b0, w_funct3};
                endcase
            end
            c_OPC_OP_32: begin
                w_a = bus.rs1_data;
                w_b = bus.rs2_data;
                case ({w_funct7, w_funct3})
                    {c_F7_BASE, 3'b000}: w_ctrl = c_ALU_ADDW;
                    {c_F7_ALT,  3'b000}: w_ctrl = c_ALU_SUBW;
                    {c_F7_BASE, 3'b001}: w_ctrl = c_ALU_SLLW;
                    {c_F7_BASE, 3'b101}: w_ctrl = c_ALU_SRLW;
                    {c_F7_ALT,  3'b101}: w_ctrl = c_ALU_SRAW;
                    default:             w_ill  = 1'b1;
                endcase
            end
            c_OPC_OP_IMM32: begin
                w_a = bus.rs1_data;
                case (w_funct3)
                    3'b000: begin
                        w_b    = w_imm_i;
                        w_ctrl = c_ALU_ADDW;
                    end
                    3'b001: begin
                        // funct7 check also rejects inst[25]=1
                        w_b = w_shamt5;
                        if (w_funct7 == c_F7_BASE) w_ctrl = c_ALU_SLLW;
                        else                       w_ill  = 1'b1;
                    end
                    3'b101: begin
                        w_b = w_shamt5;
                        if (w_funct7 == c_F7_BASE)     w_ctrl = c_ALU_SRLW;
                        else if (w_funct7 == c_F7_ALT) w_ctrl = c_ALU_SRAW;
                        else                           w_ill  = 1'b1;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            c_OPC_LUI: begin
                w_a = '0;
                w_b = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_a = bus.pc;
                w_b = w_imm_u;
            end
            default: begin
                w_known = 1'b0;
                w_ill   = 1'b1;
            end
        endcase
        // Illegal bundles are issued with neutral control and operands
        if (w_ill) begin
            w_ctrl = c_ALU_ADD;
            w_a    = '0;
            w_b    = '0;
        end
    end

    assign w_rd  = w_known ? bus.inst[11:7] : 5'd0;
    assign w_wen = !w_ill && (w_rd != 5'd0);

    // Pipeline register state
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       ctrl_q;
    logic [4:0]       rd_q;
    logic             wen_q;
    logic             ill_q;
    logic             w_in_ready;
    logic             w_load;

    assign w_in_ready = !valid_q || bus.out_ready;

    // Handshake next-state: flush beats load, load beats drain
    always_comb begin
        w_load  = bus.in_valid && w_in_ready && !bus.flush;
        valid_d = valid_q;
        if (bus.flush)                        valid_d = 1'b0;
        else if (w_load)                      valid_d = 1'b1;
        else if (valid_q && bus.out_ready)    valid_d = 1'b0;
    end

    // Issue register: reset clears everything, a load captures the decode
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= 4'd0;
            rd_q    <= 5'd0;
            wen_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (w_load) begin
                a_q    <= w_a;
                b_q    <= w_b;
                ctrl_q <= w_ctrl;
                rd_q   <= w_rd;
                wen_q  <= w_wen;
                ill_q  <= w_ill;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = valid_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_ctrl  = ctrl_q;
    assign bus.rd        = rd_q;
    assign bus.rd_wen    = wen_q;
    assign bus.illegal   = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_ex_issue.sv
// ============================================================================
// Module      : tb_riscv_ex_issue
// Description : Self-checking bench for riscv_ex_issue: directed scenarios
//               followed by randomized instructions generated from a
//               mnemonic table that carries its own expected ALU bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_ex_issue;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
        logic        rd_dc;
    } item_t;

    localparam int FR = 0, FI = 1, FS6 = 2, FS5 = 3, FLUI = 4, FAUI = 5;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    riscv_ex_issue_if #(.WIDTH(64)) bus ();

    riscv_ex_issue #(.WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Expected contents of the issue register
    logic        m_valid;
    logic [63:0] m_a, m_b;
    logic [3:0]  m_ctrl;
    logic [4:0]  m_rd;
    logic        m_wen, m_ill, m_rd_dc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic item_t mk(input logic [31:0] inst, input logic [63:0] pc, rs1, rs2,
                                 input logic [3:0] ctrl, input logic [63:0] a, b,
                                 input logic [4:0] rd, input logic wen, ill, rd_dc);
        item_t it;
        it.inst = inst; it.pc = pc; it.rs1 = rs1; it.rs2 = rs2;
        it.ctrl = ctrl; it.a = a; it.b = b; it.rd = rd;
        it.wen = wen; it.ill = ill; it.rd_dc = rd_dc;
        return it;
    endfunction

    // Build a random instruction of mnemonic k with its expected ALU bundle
    function automatic item_t gen_item(input int k);
        item_t       it;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [3:0]  ctrl;
        logic [4:0]  rd, r1f, r2f, sh5;
        logic [5:0]  sh6;
        logic [11:0] imm12;
        logic [19:0] imm20;
        int          form;
        bit          legal;
        it.pc  = {$urandom, $urandom};
        it.rs1 = {$urandom, $urandom};
        it.rs2 = {$urandom, $urandom};
        rd = 5'($urandom_range(0, 31)); r1f = 5'($urandom); r2f = 5'($urandom);
        sh5 = 5'($urandom); sh6 = 6'($urandom); imm12 = 12'($urandom); imm20 = 20'($urandom);
        op = 7'h00; f3 = 3'd0; f7 = 7'h00; ctrl = 4'h0; form = FR; legal = 1'b1;
        it.inst = 32'h0;
        case (k)
            0:  begin op = 7'h33; f3 = 3'd0; f7 = 7'h00; form = FR;  ctrl = 4'h0; end
            1:  begin op = 7'h33; f3 = 3'd0; f7 = 7'h20; form = FR;  ctrl = 4'h8; end
            2:  begin op = 7'h33; f3 = 3'd1; f7 = 7'h00; form = FR;  ctrl = 4'h1; end
            3:  begin op = 7'h33; f3 = 3'd2; f7 = 7'h00; form = FR;  ctrl = 4'h2; end
            4:  begin op = 7'h33; f3 = 3'd3; f7 = 7'h00; form = FR;  ctrl = 4'h3; end
            5:  begin op = 7'h33; f3 = 3'd4; f7 = 7'h00; form = FR;  ctrl = 4'h4; end
            6:  begin op = 7'h33; f3 = 3'd5; f7 = 7'h00; form = FR;  ctrl = 4'h5; end
            7:  begin op = 7'h33; f3 = 3'd5; f7 = 7'h20; form = FR;  ctrl = 4'hD; end
            8:  begin op = 7'h33; f3 = 3'd6; f7 = 7'h00; form = FR;  ctrl = 4'h6; end
            9:  begin op = 7'h33; f3 = 3'd7; f7 = 7'h00; form = FR;  ctrl = 4'h7; end
            10: begin op = 7'h13; f3 = 3'd0; form = FI;  ctrl = 4'h0; end
            11: begin op = 7'h13; f3 = 3'd2; form = FI;  ctrl = 4'h2; end
            12: begin op = 7'h13; f3 = 3'd3; form = FI;  ctrl = 4'h3; end
            13: begin op = 7'h13; f3 = 3'd4; form = FI;  ctrl = 4'h4; end
            14: begin op = 7'h13; f3 = 3'd6; form = FI;  ctrl = 4'h6; end
            15: begin op = 7'h13; f3 = 3'd7; form = FI;  ctrl = 4'h7; end
            16: begin op = 7'h13; f3 = 3'd1; f7 = 7'h00; form = FS6; ctrl = 4'h1; end
            17: begin op = 7'h13; f3 = 3'd5; f7 = 7'h00; form = FS6; ctrl = 4'h5; end
            18: begin op = 7'h13; f3 = 3'd5; f7 = 7'h20; form = FS6; ctrl = 4'hD; end
            19: begin op = 7'h3B; f3 = 3'd0; f7 = 7'h00; form = FR;  ctrl = 4'h9; end
            20: begin op = 7'h3B; f3 = 3'd0; f7 = 7'h20; form = FR;  ctrl = 4'hA; end
            21: begin op = 7'h3B; f3 = 3'd1; f7 = 7'h00; form = FR;  ctrl = 4'hB; end
            22: begin op = 7'h3B; f3 = 3'd5; f7 = 7'h00; form = FR;  ctrl = 4'hC; end
            23: begin op = 7'h3B; f3 = 3'd5; f7 = 7'h20; form = FR;  ctrl = 4'hE; end
            24: begin op = 7'h1B; f3 = 3'd0; form = FI;  ctrl = 4'h9; end
            25: begin op = 7'h1B; f3 = 3'd1; f7 = 7'h00; form = FS5; ctrl = 4'hB; end
            26: begin op = 7'h1B; f3 = 3'd5; f7 = 7'h00; form = FS5; ctrl = 4'hC; end
            27: begin op = 7'h1B; f3 = 3'd5; f7 = 7'h20; form = FS5; ctrl = 4'hE; end
            28: begin op = 7'h37; form = FLUI; ctrl = 4'h0; end
            29: begin op = 7'h17; form = FAUI; ctrl = 4'h0; end
            30: begin legal = 1'b0; it.inst = {7'b0000001, r2f, r1f, 3'($urandom), rd, 7'h33}; end
            31: begin legal = 1'b0; it.inst = {imm12, r1f, 3'($urandom), rd, 7'h03}; end
            32: begin legal = 1'b0; it.inst = {6'b000000, 1'b1, sh5, r1f, 3'b001, rd, 7'h1B}; end
            33: begin legal = 1'b0; it.inst = {7'h20, r2f, r1f, 3'(1 + $urandom_range(0, 3)), rd, 7'h33}; end
            34: begin legal = 1'b0; it.inst = {7'h00, r2f, r1f, 3'b010, rd, 7'h3B}; end
            default: begin legal = 1'b0; it.inst = {6'b110000, sh6, r1f, 3'b101, rd, 7'h13}; end
        endcase
        if (legal) begin
            it.a = it.rs1;
            case (form)
                FR:  begin it.inst = {f7, r2f, r1f, f3, rd, op};      it.b = it.rs2; end
                FI:  begin it.inst = {imm12, r1f, f3, rd, op};        it.b = {{52{imm12[11]}}, imm12}; end
                FS6: begin it.inst = {f7[6:1], sh6, r1f, f3, rd, op}; it.b = {58'd0, sh6}; end
                FS5: begin it.inst = {f7, sh5, r1f, f3, rd, op};      it.b = {59'd0, sh5}; end
                FLUI: begin it.inst = {imm20, rd, op}; it.a = 64'd0; it.b = {{32{imm20[19]}}, imm20, 12'd0}; end
                default: begin it.inst = {imm20, rd, op}; it.a = it.pc; it.b = {{32{imm20[19]}}, imm20, 12'd0}; end
            endcase
            it.ctrl = ctrl; it.rd = rd; it.wen = (rd != 5'd0); it.ill = 1'b0; it.rd_dc = 1'b0;
        end else begin
            it.ctrl = 4'h0; it.a = 64'd0; it.b = 64'd0; it.rd = 5'd0;
            it.wen = 1'b0; it.ill = 1'b1; it.rd_dc = 1'b1;
        end
        return it;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'(m_valid));
        chk({tag, ".a"},     bus.alu_a, m_a);
        chk({tag, ".b"},     bus.alu_b, m_b);
        chk({tag, ".ctrl"},  64'(bus.alu_ctrl), 64'(m_ctrl));
        if (!m_rd_dc) chk({tag, ".rd"}, 64'(bus.rd), 64'(m_rd));
        chk({tag, ".wen"},   64'(bus.rd_wen), 64'(m_wen));
        chk({tag, ".ill"},   64'(bus.illegal), 64'(m_ill));
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs
    task automatic cycle(input string tag, input item_t it, input logic iv, ordy, fl, rs);
        bus.inst = it.inst; bus.pc = it.pc; bus.rs1_data = it.rs1; bus.rs2_data = it.rs2;
        bus.in_valid = iv; bus.out_ready = ordy; bus.flush = fl; rst = rs;
        #1;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(!m_valid || ordy));
        if (rs) begin
            m_valid = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_rd = 0; m_wen = 0; m_ill = 0; m_rd_dc = 0;
        end else if (fl) begin
            m_valid = 0;
        end else if (iv && (!m_valid || ordy)) begin
            m_valid = 1; m_a = it.a; m_b = it.b; m_ctrl = it.ctrl; m_rd = it.rd;
            m_wen = it.wen; m_ill = it.ill; m_rd_dc = it.rd_dc;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    item_t add_i, sraiw_i, lui_i, mul_i, ld_i, slliw_i, x1, x2, idle;

    initial begin
        add_i   = mk(32'h002081B3, 64'h1000, 64'd5, 64'd7, 4'h0, 64'd5, 64'd7, 5'd3, 1'b1, 1'b0, 1'b0);
        sraiw_i = mk(32'h4033529B, 64'h2000, 64'h8000_0000_F000_0000, 64'd9, 4'hE,
                     64'h8000_0000_F000_0000, 64'd3, 5'd5, 1'b1, 1'b0, 1'b0);
        lui_i   = mk(32'h800000B7, 64'h3000, 64'h1234, 64'h5678, 4'h0, 64'd0,
                     64'hFFFF_FFFF_8000_0000, 5'd1, 1'b1, 1'b0, 1'b0);
        mul_i   = mk(32'h022081B3, 64'h4000, 64'd11, 64'd12, 4'h0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        ld_i    = mk(32'h00003083, 64'h5000, 64'd13, 64'd14, 4'h0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        slliw_i = mk(32'h0220909B, 64'h6000, 64'd15, 64'd16, 4'h0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle    = gen_item(0);

        // Initial reset without pre-reset checks
        bus.in_valid = 0; bus.out_ready = 0; bus.flush = 0;
        bus.inst = 0; bus.pc = 0; bus.rs1_data = 0; bus.rs2_data = 0;
        rst = 1;
        @(posedge clk); #1;
        m_valid = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_rd = 0; m_wen = 0; m_ill = 0; m_rd_dc = 0;
        check_all("reset0");

        // Reset drops a held bundle
        cycle("hold", add_i, 1, 0, 0, 0);
        cycle("rst_held", add_i, 1, 0, 0, 1);
        cycle("idle0", idle, 0, 0, 0, 0);

        // Directed decodes
        cycle("add", add_i, 1, 1, 0, 0);
        cycle("sraiw", sraiw_i, 1, 1, 0, 0);
        cycle("lui", lui_i, 1, 1, 0, 0);
        cycle("drain", idle, 0, 1, 0, 0);

        // Back-to-back with a 3-cycle stall
        x1 = gen_item(5);
        x2 = gen_item(22);
        cycle("b2b_first", x1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("b2b_stall", x2, 1, 0, 0, 0);
        cycle("b2b_second", x2, 1, 1, 0, 0);
        cycle("b2b_drain", idle, 0, 1, 0, 0);

        // Flush kills held and incoming bundles
        cycle("fl_load", x1, 1, 0, 0, 0);
        cycle("flush", x2, 1, 1, 1, 0);
        cycle("fl_load2", x2, 1, 0, 0, 0);
        cycle("flush_rst", x1, 1, 1, 1, 1);

        // Illegal encodings
        cycle("mul", mul_i, 1, 1, 0, 0);
        cycle("load", ld_i, 1, 1, 0, 0);
        cycle("slliw25", slliw_i, 1, 1, 0, 0);
        cycle("legal_after", add_i, 1, 1, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            item_t it;
            it = gen_item($urandom_range(0, 35));
            cycle("rand", it, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
